babbage_inv: RTL and testbench
==============================

Name: babbage_inv

Overview:
- Inverse companion to the forward difference engine babbage_diff, which computes f(n) = 2n^3 + 3n^2 + 4n + 5 for a 6-bit n.
- Given a target value y, finds the largest n in [0, N_MAX] with f(n) <= y.
- Steps the same forward-difference recurrence one term per clock, using adders only, with no multipliers.
- Sits beside babbage_diff behind the same start/ready/done_tick handshake, so one controller can drive both.

Parameters:
- W, 20, datapath width of y and of the internal f/d1/d2 registers. f(64) = 536837 fits in 20 bits.
- N_MAX, 63, largest index searched. The n output is clog2(N_MAX+1) = 6 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request; sampled only while ready=1.
- y  in  W  target value; latched on the accepted start.
- n  out  6  result index.
- exact  out  1  1 when f(n) == y.
- under  out  1  1 when y < f(0) = 5; n is then 0.
- sat  out  1  1 when the search stopped at N_MAX because f(N_MAX) < y.
- ready  out  1  1 in IDLE.
- done_tick  out  1  one-cycle pulse when n, exact, under and sat are valid.

Behaviour:
- Reset (async, rst=1): state=IDLE, n=0, exact=0, under=0, sat=0, ready=1, done_tick=0, internal registers=0.
- Result outputs are registered. They hold their value from done_tick until the next accepted start, then are cleared to 0.
- FSM states: IDLE, OP, DONE.
- IDLE:
  - ready=1.
  - On start=1: latch y; load f=5, d1=9, d2=18, k=0; go to OP.
  - start while not ready is ignored.
- OP, one decision per cycle (nf = f + d1 = f(k+1)):
  1. If k==0 and y < f: under=1, n=0 → DONE.
  2. Else if k==N_MAX: n=k, exact=(f==y), sat=(f<y) → DONE.
  3. Else if nf > y: n=k, exact=(f==y) → DONE.
  4. Else: f<=nf, d1<=d1+d2, d2<=d2+12, k<=k+1; stay in OP.
- DONE: done_tick=1 for exactly one cycle, then go to IDLE (ready=1 on the next cycle).
- Latency: for a result n, OP occupies n+1 cycles. done_tick is high during cycle n+2, counting the start-accept edge as edge 0. Worst case is 65 cycles.
- Arithmetic: all unsigned, W bits. With W=20 no add overflows for N_MAX=63, so no wrap handling is needed. Comparisons are unsigned.
- start held high through DONE is ignored. It is re-accepted in IDLE, so back-to-back requests lose exactly one cycle.
- rst asserted mid-search aborts immediately to the reset state. No done_tick is issued.
- y changing after acceptance has no effect.

Optional Feature:
- Macro: BABBAGE_INV_FVAL_EN.
- Defined: adds output port fval [W-1:0], registered with the other results.
  - Equals f(n) at done_tick.
  - Equals 5 when under=1.
  - Reset value 0.
  - Lets a controller check the result against babbage_diff without a second run.
- Undefined: no fval port and no extra register. All other behaviour is identical.

Decomposition:
- Package babbage_pkg holds:
  - coefficient constants F0=5, D1_0=9, D2_0=18, D3=12;
  - state encodings IDLE/OP/DONE;
  - W and N_MAX defaults.
- babbage_diff should import the same constants.
- One natural sub-module: babbage_step, a combinational-plus-register difference accumulator.
  - Loads F0/D1_0/D2_0 on load, advances one term on adv.
  - Exposes f and nf.
  - The same step logic applies to the forward engine.

Test Plan:
- y=41 → done_tick in cycle 4 after start; n=2, exact=1, under=0, sat=0.
- y=97 → n=2, exact=0. Then y=98 → n=3, exact=1 (f(3)=98).
- y=4 → done_tick in cycle 2; n=0, under=1, exact=0. Then y=5 → n=0, exact=1, under=0.
- y=600000 → done_tick in cycle 65; n=63, sat=1, exact=0. Then y=512258 → n=63, exact=1, sat=0.
- Sweep n=0..63: y=f(n) must return n with exact=1, and y=f(n)+1 must return n with exact=0 (except n=63, which sets sat). With BABBAGE_INV_FVAL_EN defined, fval must equal f(n) in every case.
- Reset and handshake:
  - Start y=512258; assert rst at cycle 10 → no done_tick, outputs 0, ready=1. Then a new start with y=14 returns n=1, exact=1.
  - start pulsed while ready=0 has no effect on the result.

Source files
------------

// File: rtl/babbage_pkg.sv
// Shared constants for the forward/inverse Babbage difference engines.
// The coefficients generate f(n) = 2n^3 + 3n^2 + 4n + 5 from n = 0 upward.
package babbage_pkg;

    localparam int W_DEF     = 20;
    localparam int N_MAX_DEF = 63;

    // Initial f, first and second differences, and the constant third difference
    localparam int F0   = 5;
    localparam int D1_0 = 9;
    localparam int D2_0 = 18;
    localparam int D3   = 12;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OP   = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/babbage_step.sv
// Difference accumulator: loads f(0) and its differences, advances one term per adv.
// o_nf is the next term f(k+1), available combinationally alongside f(k).
module babbage_step
    import babbage_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic         i_adv,
    output logic [W-1:0] o_f,
    output logic [W-1:0] o_nf
);

    logic [W-1:0] r_f;
    logic [W-1:0] r_d1;
    logic [W-1:0] r_d2;
    logic [W-1:0] w_nf;

    assign w_nf = r_f + r_d1;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_f  <= '0;
            r_d1 <= '0;
            r_d2 <= '0;
        end else if (i_load) begin
            r_f  <= W'(F0);
            r_d1 <= W'(D1_0);
            r_d2 <= W'(D2_0);
        end else if (i_adv) begin
            r_f  <= w_nf;
            r_d1 <= r_d1 + r_d2;
            r_d2 <= r_d2 + W'(D3);
        end
    end

    assign o_f  = r_f;
    assign o_nf = w_nf;

endmodule

// File: rtl/babbage_inv.sv
// Inverse Babbage engine: largest n in [0, N_MAX] with f(n) <= y, one term per clock.
// Optional fval result port is enabled by defining BABBAGE_INV_FVAL_EN.
//
// state | meaning
// IDLE  | ready=1, waiting for start; latches y and loads the accumulator
// OP    | one compare/advance per cycle over k = 0..N_MAX
// DONE  | one-cycle done_tick with results valid, then back to IDLE
module babbage_inv
    import babbage_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int N_MAX = N_MAX_DEF,
    localparam int NW   = $clog2(N_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [W-1:0]  y,
    output logic [NW-1:0] n,
    output logic          exact,
    output logic          under,
    output logic          sat,
    output logic          ready,
    output logic          done_tick
`ifdef BABBAGE_INV_FVAL_EN
    ,
    output logic [W-1:0]  fval
`endif
);

    state_t        r_state;
    state_t        w_next;

    logic [W-1:0]  r_y;
    logic [NW-1:0] r_k;
    logic [NW-1:0] r_n;
    logic          r_exact;
    logic          r_under;
    logic          r_sat;

    logic [W-1:0]  w_f;
    logic [W-1:0]  w_nf;
    logic          w_under_hit;
    logic          w_at_max;
    logic          w_over;
    logic          w_load;
    logic          w_adv;
    logic          w_fin;

    babbage_step #(.W(W)) u_step (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_load (w_load),
        .i_adv  (w_adv),
        .o_f    (w_f),
        .o_nf   (w_nf)
    );

    assign w_under_hit = (r_k == '0) && (r_y < w_f);
    assign w_at_max    = (r_k == NW'(N_MAX));
    assign w_over      = (w_nf > r_y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = OP;
            OP:      if (w_fin) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_load    = 1'b0;
        w_adv     = 1'b0;
        w_fin     = 1'b0;
        ready     = 1'b0;
        done_tick = 1'b0;
        case (r_state)
            IDLE: begin
                ready  = 1'b1;
                w_load = start;
            end
            OP: begin
                w_fin = w_under_hit || w_at_max || w_over;
                w_adv = !w_fin;
            end
            DONE:    done_tick = 1'b1;
            default: ;
        endcase
    end

    // Results are cleared on acceptance and captured on the deciding OP cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y     <= '0;
            r_k     <= '0;
            r_n     <= '0;
            r_exact <= 1'b0;
            r_under <= 1'b0;
            r_sat   <= 1'b0;
        end else if (w_load) begin
            r_y     <= y;
            r_k     <= '0;
            r_n     <= '0;
            r_exact <= 1'b0;
            r_under <= 1'b0;
            r_sat   <= 1'b0;
        end else if (w_adv) begin
            r_k <= r_k + 1'b1;
        end else if (w_fin) begin
            r_n     <= w_under_hit ? '0 : r_k;
            r_exact <= !w_under_hit && (w_f == r_y);
            r_under <= w_under_hit;
            r_sat   <= !w_under_hit && w_at_max && (w_f < r_y);
        end
    end

    assign n     = r_n;
    assign exact = r_exact;
    assign under = r_under;
    assign sat   = r_sat;

`ifdef BABBAGE_INV_FVAL_EN
    logic [W-1:0] r_fval;

    // On an under result k is 0, so f still holds f(0) = 5
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fval <= '0;
        end else if (w_load) begin
            r_fval <= '0;
        end else if (w_fin) begin
            r_fval <= w_f;
        end
    end

    assign fval = r_fval;
`endif

endmodule

// File: tb/tb_babbage_inv.sv
// Directed bench for babbage_inv: latency, result flags, boundaries, reset and handshake.
module tb_babbage_inv;

    logic        clk;
    logic        rst;
    logic        start;
    logic [19:0] y;
    logic [5:0]  n;
    logic        exact;
    logic        under;
    logic        sat;
    logic        ready;
    logic        done_tick;
`ifdef BABBAGE_INV_FVAL_EN
    logic [19:0] fval;
`endif

    int total = 0;
    int bad   = 0;

    babbage_inv dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .y         (y),
        .n         (n),
        .exact     (exact),
        .under     (under),
        .sat       (sat),
        .ready     (ready),
        .done_tick (done_tick)
`ifdef BABBAGE_INV_FVAL_EN
        ,
        .fval      (fval)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int fref(input int k);
        return 2*k*k*k + 3*k*k + 4*k + 5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run(input string tag, input int yv, input int en,
                       input logic ee, input logic eu, input logic es);
        int  cyc;
        bit  seen;
        @(negedge clk);
        chk($sformatf("%s ready_idle", tag), 32'(ready), 1);
        y     = 20'(yv);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        y     = 20'hFFFFF;
        chk($sformatf("%s cleared", tag), {28'd0, exact, under, sat, ready} | {26'd0, n} , 0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 70) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done_tick) seen = 1'b1;
        end
        chk($sformatf("%s latency", tag), 32'(cyc), 32'(en + 1));
        chk($sformatf("%s n", tag), 32'(n), 32'(en));
        chk($sformatf("%s exact", tag), 32'(exact), 32'(ee));
        chk($sformatf("%s under", tag), 32'(under), 32'(eu));
        chk($sformatf("%s sat", tag), 32'(sat), 32'(es));
`ifdef BABBAGE_INV_FVAL_EN
        chk($sformatf("%s fval", tag), 32'(fval), 32'(fref(en)));
`endif
        @(posedge clk);
        #1;
        chk($sformatf("%s tick_one", tag), 32'(done_tick), 0);
        chk($sformatf("%s ready_back", tag), 32'(ready), 1);
        chk($sformatf("%s n_hold", tag), 32'(n), 32'(en));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        y     = '0;
        #12;
        chk("rst n", 32'(n), 0);
        chk("rst flags", {29'd0, exact, under, sat}, 0);
        chk("rst ready", 32'(ready), 1);
        chk("rst tick", 32'(done_tick), 0);
        @(negedge clk);
        rst = 1'b0;

        run("y41", 41, 2, 1'b1, 1'b0, 1'b0);
        run("y97", 97, 2, 1'b0, 1'b0, 1'b0);
        run("y98", 98, 3, 1'b1, 1'b0, 1'b0);
        run("y4", 4, 0, 1'b0, 1'b1, 1'b0);
        run("y5", 5, 0, 1'b1, 1'b0, 1'b0);
        run("y0", 0, 0, 1'b0, 1'b1, 1'b0);
        run("y600000", 600000, 63, 1'b0, 1'b0, 1'b1);
        run("y512258", 512258, 63, 1'b1, 1'b0, 1'b0);
        run("y512257", 512257, 62, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 64; k++) begin
            run($sformatf("sweep_eq%0d", k), fref(k), k, 1'b1, 1'b0, 1'b0);
            run($sformatf("sweep_p1_%0d", k), fref(k) + 1, k, 1'b0, 1'b0, (k == 63));
        end

        // Abort a long search with reset part-way through
        @(negedge clk);
        y     = 20'd512258;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("abort n", 32'(n), 0);
        chk("abort flags", {29'd0, exact, under, sat}, 0);
        chk("abort ready", 32'(ready), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("abort no_tick", 32'(done_tick), 0);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            chk("post_abort idle", {30'd0, done_tick, ready}, 1);
        end
        run("after_rst_y14", 14, 1, 1'b1, 1'b0, 1'b0);

        // A start pulse while busy must not disturb the running search
        @(negedge clk);
        y     = 20'd98;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy ready", 32'(ready), 0);
        y     = 20'd4;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int  cyc;
            bit  seen;
            cyc  = 0;
            seen = 1'b0;
            while (!seen && cyc < 70) begin
                @(posedge clk);
                #1;
                cyc++;
                if (done_tick) seen = 1'b1;
            end
            chk("busy seen", 32'(seen), 1);
            chk("busy n", 32'(n), 3);
            chk("busy exact", 32'(exact), 1);
            chk("busy under", 32'(under), 0);
        end
        @(posedge clk);
        #1;
        chk("busy idle_after", 32'(ready), 1);
        chk("busy n_hold", 32'(n), 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
